// File: rtl/crc32_pkg.sv
// crc32_pkg: CRC-32 constants and the status/state types shared by the frame checker and the TX generator.
package crc32_pkg;
  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_FCS = 2'd1, ERR_LEN = 2'd2, ERR_ABORT = 2'd3} err_e;
  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_e;
endpackage

// File: rtl/crc32_frame_checker_if.sv
// crc32_frame_checker_if: input/output beat streams and statistics of the CRC-32 frame checker.
interface crc32_frame_checker_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic [31:0] in_fcs;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_ok;
  logic [1:0]  out_err;
  logic [15:0] cnt_good;
  logic [15:0] cnt_bad;
  modport master (
    output in_valid, in_data, in_sop, in_eop, in_fcs, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_ok, out_err, cnt_good, cnt_bad
  );
  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_fcs, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_ok, out_err, cnt_good, cnt_bad
  );
endinterface

// File: rtl/crc32_step64.sv
// crc32_step64: one 64-bit MSB-first CRC-32 update, data[63] shifted in first; purely combinational.
module crc32_step64
  import crc32_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [63:0] data_i,
  output logic [31:0] crc_o
);
  logic [31:0] c;
  always_comb begin
    c = crc_i;
    for (int i = 63; i >= 0; i--) c = {c[30:0], 1'b0} ^ ((c[31] ^ data_i[i]) ? CRC32_POLY : 32'h0);
    crc_o = c;
  end
endmodule

// File: rtl/crc32_frame_checker.sv
// crc32_frame_checker: registered-stage RX frame checker with CRC-32 FCS, length and framing policing.
// Define STAT_COUNTERS_EN to implement the saturating cnt_good/cnt_bad counters (tied to 0 otherwise).
module crc32_frame_checker
  import crc32_pkg::*;
#(
  parameter int MAX_WORDS = 256
) (
  input logic clk,
  input logic rst_n,
  crc32_frame_checker_if.slave bus
);
  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);
  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_base, crc_nx;
  logic [15:0] wcnt_q, wcnt_d;
  logic        len_err_q, len_err_d;
  logic        out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d, out_ok_q, out_ok_d;
  logic [63:0] out_data_q, out_data_d;
  err_e        out_err_q, out_err_d, err;
  logic        in_ready, acc, fwd, abort, ovf, len_now, ok;
  assign in_ready = !out_valid_q || bus.out_ready;
  assign acc      = bus.in_valid && in_ready;
  assign fwd      = acc && (state_q == FRAME || bus.in_sop);
  assign abort    = state_q == FRAME && bus.in_sop;
  // A sop restarts the frame, so prior length trouble never leaks into the new one
  assign ovf      = state_q == FRAME && !bus.in_sop && wcnt_q >= MAX_W;
  assign len_now  = !bus.in_sop && (len_err_q || ovf);
  assign crc_base = (state_q == IDLE || bus.in_sop) ? CRC32_INIT : crc_q;
  crc32_step64 u_step (.crc_i(crc_base), .data_i(bus.in_data), .crc_o(crc_nx));
  assign ok  = !abort && bus.in_eop && !len_now && crc_nx == bus.in_fcs;
  assign err = abort ? ERR_ABORT : !bus.in_eop ? ERR_NONE : len_now ? ERR_LEN : crc_nx != bus.in_fcs ? ERR_FCS : ERR_NONE;
  always_comb begin
    state_d     = fwd ? (bus.in_eop ? IDLE : FRAME) : state_q;
    crc_d       = fwd ? (bus.in_eop ? CRC32_INIT : crc_nx) : crc_q;
    wcnt_d      = fwd ? (bus.in_sop ? 16'd1 : wcnt_q + 16'(wcnt_q != 16'hFFFF)) : wcnt_q;
    len_err_d   = fwd ? (!bus.in_eop && len_now) : len_err_q;
    out_valid_d = acc ? fwd : (bus.out_ready ? 1'b0 : out_valid_q);
    out_data_d  = fwd ? bus.in_data : out_data_q;
    out_sop_d   = fwd ? bus.in_sop : out_sop_q;
    out_eop_d   = fwd ? bus.in_eop : out_eop_q;
    out_ok_d    = fwd ? ok : out_ok_q;
    out_err_d   = fwd ? err : out_err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crc_q       <= CRC32_INIT;
      wcnt_q      <= '0;
      len_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_ok_q    <= 1'b0;
      out_err_q   <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      wcnt_q      <= wcnt_d;
      len_err_q   <= len_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_ok_q    <= out_ok_d;
      out_err_q   <= out_err_d;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_ok    = out_ok_q;
  assign bus.out_err   = out_err_q;
`ifdef STAT_COUNTERS_EN
  logic [15:0] good_q, bad_q;
  logic        good_inc, bad_inc;
  // Stray beats and aborts count as bad frames alongside failed eops
  assign good_inc = fwd && ok;
  assign bad_inc  = acc && (!fwd || abort || (bus.in_eop && !ok));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_q + 16'(good_inc && good_q != 16'hFFFF);
      bad_q  <= bad_q + 16'(bad_inc && bad_q != 16'hFFFF);
    end
  end
  assign bus.cnt_good = good_q;
  assign bus.cnt_bad  = bad_q;
`else
  assign bus.cnt_good = '0;
  assign bus.cnt_bad  = '0;
`endif
endmodule

// File: tb/tb_crc32_frame_checker.sv
// tb_crc32_frame_checker: table-driven frame vectors plus back-pressure and mid-frame reset sequences.
module tb_crc32_frame_checker;
  typedef struct {
    logic [63:0] d;
    logic        s, e, flip, fwd, ok;
    logic [1:0]  err;
  } vec_t;
  typedef struct {
    logic [63:0] d;
    logic        s, e, ok;
    logic [1:0]  err;
  } exp_t;

  logic clk = 0, rst_n = 0;
  int   n_chk = 0, n_fail = 0;
  crc32_frame_checker_if bus ();
  crc32_frame_checker #(.MAX_WORDS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  vec_t tv[24];
  int   nt = 0;
  exp_t q[$];
  exp_t mx;
  logic mon_en = 0, bp_en = 0, stall = 0;
  logic [63:0] snap;

  function automatic logic [31:0] mcrc(input logic [31:0] c, input logic [63:0] d);
    for (int h = 0; h < 2; h++) begin
      c ^= h == 0 ? d[63:32] : d[31:0];
      for (int b = 0; b < 32; b++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic add(input logic [63:0] d, input logic s, e, flip, fwd, ok, input logic [1:0] err);
    tv[nt] = '{d, s, e, flip, fwd, ok, err};
    nt++;
  endtask

  task automatic send(input logic [63:0] d, input logic s, e, input logic [31:0] f, input logic xok);
    int k = 0;
    @(negedge clk);
    bus.in_valid = 1; bus.in_data = d; bus.in_sop = s; bus.in_eop = e; bus.in_fcs = f;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (!bus.in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    q.push_back('{d, s, e, e && xok, (e && !xok) ? 2'd1 : 2'd0});
    @(posedge clk);
    #1 bus.in_valid = 0;
  endtask

  initial begin
    bus.out_ready = 1;
    forever begin
      @(posedge clk);
      #1 if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_data", bus.out_data, snap);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL mon_extra: got beat %0h expected none", bus.out_data);
        end else begin
          mx = q.pop_front();
          chk("mon_data", bus.out_data, mx.d);
          chk("mon_sop", 64'(bus.out_sop), 64'(mx.s));
          chk("mon_eop", 64'(bus.out_eop), 64'(mx.e));
          chk("mon_ok", 64'(bus.out_ok), 64'(mx.ok));
          chk("mon_err", 64'(bus.out_err), 64'(mx.err));
        end
      end
      stall = bus.out_valid && !bus.out_ready;
      snap  = bus.out_data;
    end else stall = 0;
  end

  initial begin
    logic [31:0] r;
    logic [63:0] d;
    int g_exp, b_exp;
    bus.in_valid = 0; bus.in_data = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_fcs = 0;
    add(64'h0123456789ABCDEF, 1, 0, 0, 1, 0, 0);
    add(64'hFFFFFFFF00000000, 0, 0, 0, 1, 0, 0);
    add(64'h0000000000000000, 0, 1, 0, 1, 1, 0);
    add(64'h0123456789ABCDEF, 1, 0, 0, 1, 0, 0);
    add(64'hFFFFFFFF00000000, 0, 0, 0, 1, 0, 0);
    add(64'h0000000000000000, 0, 1, 1, 1, 0, 1);
    add(64'hDEADBEEFCAFEF00D, 0, 0, 0, 0, 0, 0);
    add(64'h1122334455667788, 1, 1, 0, 1, 1, 0);
    add(64'h1000000000000001, 1, 0, 0, 1, 0, 0);
    add(64'h2000000000000002, 0, 0, 0, 1, 0, 0);
    add(64'h3000000000000003, 0, 0, 0, 1, 0, 0);
    add(64'h4000000000000004, 0, 0, 0, 1, 0, 0);
    add(64'h5000000000000005, 0, 0, 0, 1, 0, 0);
    add(64'h6000000000000006, 0, 1, 0, 1, 0, 2);
    add(64'hA1A1A1A1A1A1A1A1, 1, 0, 0, 1, 0, 0);
    add(64'hA2A2A2A2A2A2A2A2, 0, 0, 0, 1, 0, 0);
    add(64'hB1B1B1B1B1B1B1B1, 1, 0, 0, 1, 0, 3);
    add(64'hB2B2B2B2B2B2B2B2, 0, 0, 0, 1, 0, 0);
    add(64'hB3B3B3B3B3B3B3B3, 0, 1, 0, 1, 1, 0);
    g_exp = 3;
    b_exp = 4;

    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sop", 64'(bus.out_sop), 0);
    chk("rst_out_eop", 64'(bus.out_eop), 0);
    chk("rst_out_ok", 64'(bus.out_ok), 0);
    chk("rst_out_err", 64'(bus.out_err), 0);
    chk("rst_cnt_good", 64'(bus.cnt_good), 0);
    chk("rst_cnt_bad", 64'(bus.cnt_bad), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);

    r = 32'hFFFFFFFF;
    for (int i = 0; i < nt; i++) begin
      if (tv[i].s) r = mcrc(32'hFFFFFFFF, tv[i].d);
      else if (tv[i].fwd) r = mcrc(r, tv[i].d);
      bus.in_valid = 1; bus.in_data = tv[i].d; bus.in_sop = tv[i].s; bus.in_eop = tv[i].e;
      bus.in_fcs = r ^ {31'b0, tv[i].flip};
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(tv[i].fwd));
      if (tv[i].fwd) begin
        chk($sformatf("v%0d_data", i), bus.out_data, tv[i].d);
        chk($sformatf("v%0d_sop", i), 64'(bus.out_sop), 64'(tv[i].s));
        chk($sformatf("v%0d_eop", i), 64'(bus.out_eop), 64'(tv[i].e));
        chk($sformatf("v%0d_ok", i), 64'(bus.out_ok), 64'(tv[i].ok));
        chk($sformatf("v%0d_err", i), 64'(bus.out_err), 64'(tv[i].err));
      end
    end
    bus.in_valid = 0;
    @(negedge clk);
`ifdef STAT_COUNTERS_EN
    chk("tbl_cnt_good", 64'(bus.cnt_good), 64'(g_exp));
    chk("tbl_cnt_bad", 64'(bus.cnt_bad), 64'(b_exp));
`else
    chk("tbl_cnt_good", 64'(bus.cnt_good), 0);
    chk("tbl_cnt_bad", 64'(bus.cnt_bad), 0);
`endif

    mon_en = 1;
    bp_en  = 1;
    r = 32'hFFFFFFFF;
    for (int w = 0; w < 4; w++) begin
      d = {32'hC0DE0000 + 32'(w), 32'h13579BDF ^ 32'(w * 7)};
      r = mcrc(r, d);
      send(d, w == 0, w == 3, r, 1);
    end
    d = 64'h0F0F0F0F12345678;
    r = mcrc(32'hFFFFFFFF, d);
    send(d, 1, 0, r, 0);
    d = 64'h8765432100000000;
    r = mcrc(r, d);
    send(d, 0, 1, r ^ 32'h1, 0);
    bp_en = 0;
    @(posedge clk);
    #1 bus.out_ready = 1;
    repeat (4) @(negedge clk);
    chk("bp_drain", 64'(q.size()), 0);

    send(64'h5555AAAA5555AAAA, 1, 0, 0, 0);
    send(64'h1234123412341234, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    mon_en = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_err", 64'(bus.out_err), 0);
    chk("mid_rst_cnt_good", 64'(bus.cnt_good), 0);
    @(negedge clk);
    rst_n = 1;
    q.delete();
    mon_en = 1;
    d = 64'h0BADF00D0BADF00D;
    send(d, 1, 1, mcrc(32'hFFFFFFFF, d), 1);
    repeat (3) @(negedge clk);
    chk("post_rst_drain", 64'(q.size()), 0);
`ifdef STAT_COUNTERS_EN
    chk("post_rst_cnt_good", 64'(bus.cnt_good), 1);
    chk("post_rst_cnt_bad", 64'(bus.cnt_bad), 0);
`endif
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/crc32_frame_checker.md
# crc32_frame_checker

Receive-side frame checker that sits directly downstream of the 64-bit PCIe CRC-32 engine's data path. It consumes a valid/ready stream of 64-bit words delimited by sop/eop, runs a stateful CRC-32 across every word of a frame, and compares the result with the FCS delivered on the eop beat. It forwards every beat through one registered stage, tags the eop beat with pass/fail status and error code, and polices framing and length.

## Interface
- MAX_WORDS, 256: maximum data words per frame, including the eop word; range 1..65535.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  64  data word
- in_sop  in  1  first word of frame
- in_eop  in  1  last word of frame; sop and eop may both be set
- in_fcs  in  32  expected CRC; qualified by in_eop
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  64  registered copy of in_data
- out_sop, out_eop  out  1 each  registered flags
- out_ok  out  1  on eop beat: 1 = CRC match and err == NONE
- out_err  out  2  0 NONE, 1 FCS, 2 LEN, 3 ABORT
- cnt_good, cnt_bad  out  16 each  saturating frame counters

## Operation
- CRC: polynomial 0x04C11DB7, init 0xFFFF_FFFF, MSB-first, in_data[63] shifted first, no reflection, no final XOR. crc_next = step64(crc_q, in_data).
- FSM states:
  - IDLE: accepted beat with sop → FRAME (unless eop is also set); crc_q = step64(INIT, data); wcnt = 1.
  - IDLE, accepted beat without sop: dropped, not forwarded; cnt_bad += 1.
  - FRAME, accepted beat without sop: crc_q = crc_next; wcnt += 1.
  - FRAME, accepted beat with sop: previous frame is abandoned, with no eop ever emitted for it. The forwarded sop beat carries out_err = ABORT and out_ok = 0; cnt_bad += 1. The CRC restarts from INIT on this word.
- Length: if wcnt would exceed MAX_WORDS, a sticky len_err is set. The frame continues to be forwarded. At eop, out_err = LEN takes precedence over FCS.
- At eop:
  - out_ok = (crc_next == in_fcs) && !len_err.
  - out_err = LEN if len_err, else FCS if the CRC mismatches, else NONE.
  - Increments cnt_good or cnt_bad. FSM → IDLE; len_err clears.
- out_ok and out_err are 0 on non-eop beats, except for the ABORT tag on a sop beat.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: out_valid = 0, out_data = 0, flags = 0, out_ok = 0, out_err = 0, counters = 0, FSM = IDLE, crc_q = INIT.
- in_ready = !out_valid || out_ready. This is a single register stage with no combinational path from in_valid to out_valid.
- Latency: an accepted beat appears on out_* the next cycle. While out_ready = 0, the output holds stable.
- Full throughput: one beat per clock when out_ready stays 1.
- CRC compare and status are computed combinationally at acceptance and registered with the beat.
- rst_n assertion mid-frame: immediate return to reset values; the partial frame is lost and no status is emitted.

## Configuration
- STAT_COUNTERS_EN defined: cnt_good and cnt_bad are implemented as described.
- Not defined: counter logic is removed and both ports are tied to 0. Forwarding, status and FSM are unchanged.

## Structure
- Package crc32_pkg holds:
  - CRC32_POLY, CRC32_INIT
  - err_e enum (NONE/FCS/LEN/ABORT)
  - state_e (IDLE/FRAME)
- Sub-module crc32_step64: purely combinational, (crc_in[31:0], data[63:0]) → crc_out[31:0]. It is shared with the TX-side generator.
- The checker contains the FSM, output register, length counter and stats.

## Test plan
- Three-word frame (0x0123456789ABCDEF, 0xFFFFFFFF00000000, 0x0), in_fcs = model CRC → eop beat has out_ok = 1, out_err = 0, cnt_good = 1; each beat appears one cycle after acceptance.
- Same frame with in_fcs bit 0 flipped → out_ok = 0, out_err = 1, cnt_bad = 1.
- MAX_WORDS = 4, six-word frame with correct FCS → all six beats forwarded; eop has out_err = 2, out_ok = 0.
- Frame with sop, word, then a new sop before eop → second sop beat tagged out_err = 3; the new frame checks OK independently; cnt_bad = 1, cnt_good = 1.
- Stray beat without sop in IDLE → not forwarded, cnt_bad increments. Single-beat sop + eop frame → correct status.
- out_ready toggled randomly, plus rst_n pulsed mid-frame:
  - under back-pressure, no beat lost or duplicated and out_* stable while stalled;
  - after reset, outputs are 0 and the next frame checks OK.
